lutram_fifo64x3_ctrl: RTL and testbench
=======================================

Name: lutram_fifo64x3_ctrl

Overview:
- Synchronous FIFO controller that is the initiator/driver for an external 64x4 quad-port distributed LUT-RAM: one write port (WE, write address D, DIA..DID) and asynchronous read ports A/B/C.
- Port D's read address is tied to its write address, so only bits A/B/C are readable at an arbitrary address. The controller therefore implements a 64-deep x 3-bit FIFO: write pointer on ADDRD, read pointer on ADDRA/B/C.
- Registered first-word-fall-through output stage.
- Sits between a producer and a consumer inside the same clock domain.

Parameters:
- AFULL_THRESH, 56, ALMOST_FULL asserted when COUNT >= value (range 1..65).
- AEMPTY_THRESH, 2, ALMOST_EMPTY asserted when COUNT <= value (range 0..64).

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- WR_EN  in  1  push request.
- WR_DATA  in  3  push data.
- FULL  out  1  RAM holds 64 words; push ignored.
- ALMOST_FULL  out  1  see parameter.
- RD_EN  in  1  pop request (acknowledge of RD_DATA).
- RD_DATA  out  3  head word, valid when EMPTY=0.
- EMPTY  out  1  output register empty.
- ALMOST_EMPTY  out  1  see parameter.
- COUNT  out  7  total words (RAM + output register), 0..65.
- MEM_WE  out  1  RAM write enable.
- MEM_ADDRD  out  6  write pointer.
- MEM_DIA/MEM_DIB/MEM_DIC  out  1 each  WR_DATA[0]/[1]/[2].
- MEM_DID  out  1  constant 0.
- MEM_ADDRA/MEM_ADDRB/MEM_ADDRC  out  6 each  read pointer.
- MEM_DOA/MEM_DOB/MEM_DOC  in  1 each  asynchronous read data.

Behaviour:
- Reset values:
  - wr_ptr=0, rd_ptr=0, ram_cnt=0.
  - Output register empty; RD_DATA=0; EMPTY=1; FULL=0; COUNT=0.
  - ALMOST_EMPTY=1 (AEMPTY_THRESH >= 0); ALMOST_FULL=0.
  - MEM_WE forced 0 while RST=1.
  - RAM contents are not cleared.
- Push accept: push_ok = WR_EN & ~FULL, evaluated on registered state.
  - MEM_WE = push_ok, combinational.
  - MEM_ADDRD = wr_ptr; MEM_DIx driven from WR_DATA.
  - On the edge: wr_ptr = wr_ptr+1 mod 64 (63 wraps to 0).
- Output stage, two states:
  - OUT_EMPTY: if ram_cnt>0, load {MEM_DOC,MEM_DOB,MEM_DOA} into RD_DATA, rd_ptr++, go to OUT_VALID.
  - OUT_VALID: if RD_EN and ram_cnt>0, reload from the RAM and increment rd_ptr (back-to-back throughput 1 word/clk).
  - OUT_VALID: if RD_EN and ram_cnt=0, go to OUT_EMPTY; RD_DATA holds its last value.
  - OUT_VALID without RD_EN: hold.
  - RD_EN while EMPTY=1: ignored, no pointer change.
- Latency: word pushed at edge N appears on RD_DATA with EMPTY=0 after edge N+1, provided the output register was free.
  - No write-to-read bypass. Push into an empty FIFO never loads the output register on the same edge.
- ram_cnt update: +push_ok, -refill. Simultaneous push and refill leaves ram_cnt unchanged.
- Flag derivation:
  - FULL = (ram_cnt==64), registered.
  - COUNT = ram_cnt + ~EMPTY.
- Full with simultaneous push and pop: push still rejected (FULL is the registered view). Pop refills and frees one RAM slot; FULL deasserts after that edge.
- wr_ptr==rd_ptr is ambiguous; ram_cnt is the sole full/empty discriminator.
- Reset asserted mid-operation: immediate return to reset values. An in-flight push is lost.

Optional Feature:
- Macro: LUTRAM_FIFO_ERR_EN.
- Defined: extra outputs OVERFLOW and UNDERFLOW, each 1 bit.
  - OVERFLOW is sticky-set on WR_EN & FULL.
  - UNDERFLOW is sticky-set on RD_EN & EMPTY.
  - Both cleared only by RST.
- Undefined: ports absent; no added logic.

Decomposition:
- Package lutram_fifo_pkg holds:
  - ADDR_W=6, DATA_W=3, DEPTH=64, COUNT_W=7.
  - Output-state encoding: OUT_EMPTY=0, OUT_VALID=1.
- One sub-module, lutram_fifo_out_stage: output register, state, refill decision and rd_ptr increment.
- Pointers, ram_cnt and flags stay in the top.

Test Plan:
- Reset, then push 3'b101 at edge 1 → MEM_WE=1 and MEM_ADDRD=0 during cycle 1; EMPTY=0 and RD_DATA=5 after edge 2; COUNT=1.
- 65 pushes with no pops → FULL=1 after the 65th accepted push (64 in RAM + 1 in output register); COUNT=65; 66th push gives MEM_WE=0 and wr_ptr unchanged.
- Continuous push and pop of an incrementing pattern (0..7 repeating) over 200 words → order preserved, ADDRD/ADDRA wrap 63→0 correctly, 1 word/clk after a 2-edge fill.
- Full FIFO with WR_EN=RD_EN=1 for one cycle → push rejected, head popped, COUNT=64, FULL=0 after the edge.
- RD_EN on empty FIFO → RD_DATA and rd_ptr unchanged; with LUTRAM_FIFO_ERR_EN, UNDERFLOW=1 and sticky until RST.
- RST pulse with COUNT=10 → EMPTY=1, COUNT=0, ALMOST_EMPTY=1, next push lands at address 0.

Source files
------------

// File: rtl/lutram_fifo64x3_ctrl_pkg.sv
// Shared widths and output-stage state encoding for the 64x3 LUT-RAM FIFO controller.
package lutram_fifo_pkg;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 3;
  localparam int DEPTH   = 64;
  localparam int COUNT_W = 7;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

endpackage

// File: rtl/lutram_fifo64x3_ctrl_if.sv
// Producer/consumer handshake plus LUT-RAM port bundle for the FIFO controller.
// Optional OVERFLOW/UNDERFLOW signals exist only when LUTRAM_FIFO_ERR_EN is defined.
interface lutram_fifo64x3_ctrl_if import lutram_fifo_pkg::*; ();

  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;
  logic               full;
  logic               almost_full;
  logic               rd_en;
  logic [DATA_W-1:0]  rd_data;
  logic               empty;
  logic               almost_empty;
  logic [COUNT_W-1:0] count;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addrd;
  logic               mem_dia;
  logic               mem_dib;
  logic               mem_dic;
  logic               mem_did;
  logic [ADDR_W-1:0]  mem_addra;
  logic [ADDR_W-1:0]  mem_addrb;
  logic [ADDR_W-1:0]  mem_addrc;
  logic               mem_doa;
  logic               mem_dob;
  logic               mem_doc;
`ifdef LUTRAM_FIFO_ERR_EN
  logic               overflow;
  logic               underflow;
`endif

  modport master (
    input  wr_en, wr_data, rd_en, mem_doa, mem_dob, mem_doc,
    output full, almost_full, rd_data, empty, almost_empty, count,
           mem_we, mem_addrd, mem_dia, mem_dib, mem_dic, mem_did,
           mem_addra, mem_addrb, mem_addrc
`ifdef LUTRAM_FIFO_ERR_EN
    , output overflow, underflow
`endif
  );

  modport slave (
    output wr_en, wr_data, rd_en, mem_doa, mem_dob, mem_doc,
    input  full, almost_full, rd_data, empty, almost_empty, count,
           mem_we, mem_addrd, mem_dia, mem_dib, mem_dic, mem_did,
           mem_addra, mem_addrb, mem_addrc
`ifdef LUTRAM_FIFO_ERR_EN
    , input overflow, underflow
`endif
  );

endinterface

// File: rtl/lutram_fifo64x3_ctrl_out_stage.sv
// First-word-fall-through output register: owns the read pointer and decides when to refill.
//   state     | meaning
//   OUT_EMPTY | output register holds no valid word
//   OUT_VALID | rd_data holds the FIFO head
module lutram_fifo_out_stage import lutram_fifo_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              ram_avail,
  input  logic [DATA_W-1:0] mem_do,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              refill,
  output logic [ADDR_W-1:0] rd_ptr
);

  out_state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OUT_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    refill    = 1'b0;
    case (state)
      OUT_EMPTY: begin
        if (ram_avail) begin
          refill    = 1'b1;
          state_nxt = OUT_VALID;
        end
      end
      OUT_VALID: begin
        if (rd_en) begin
          if (ram_avail) refill    = 1'b1;
          else           state_nxt = OUT_EMPTY;
        end
      end
      default: state_nxt = OUT_EMPTY;
    endcase
  end

  // rd_data keeps its last value after the final pop; only a refill changes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      rd_ptr  <= '0;
    end else if (refill) begin
      rd_data <= mem_do;
      rd_ptr  <= rd_ptr + ADDR_W'(1);
    end
  end

  assign empty = (state == OUT_EMPTY);

endmodule

// File: rtl/lutram_fifo64x3_ctrl.sv
// 64-deep x 3-bit FIFO controller driving an external quad-port LUT-RAM (write on D, read on A/B/C).
// Define LUTRAM_FIFO_ERR_EN to add sticky OVERFLOW/UNDERFLOW outputs.
module lutram_fifo64x3_ctrl import lutram_fifo_pkg::*; #(
  parameter int AFULL_THRESH  = 56,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  lutram_fifo64x3_ctrl_if.master bus
);

  localparam logic [COUNT_W-1:0] AFULL_C  = COUNT_W'(AFULL_THRESH);
  localparam logic [COUNT_W-1:0] AEMPTY_C = COUNT_W'(AEMPTY_THRESH);

  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [COUNT_W-1:0] ram_cnt, ram_cnt_nxt;
  logic               full_q;
  logic               push_ok;
  logic               refill;
  logic               empty;
  logic               out_valid;

  assign push_ok     = bus.wr_en & ~full_q;
  assign ram_cnt_nxt = ram_cnt + COUNT_W'(push_ok) - COUNT_W'(refill);

  // ram_cnt alone separates full from empty, since wr_ptr == rd_ptr in both cases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      ram_cnt <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      ram_cnt <= ram_cnt_nxt;
      full_q  <= (ram_cnt_nxt == COUNT_W'(DEPTH));
    end
  end

  lutram_fifo_out_stage u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (bus.rd_en),
    .ram_avail (ram_cnt != '0),
    .mem_do    ({bus.mem_doc, bus.mem_dob, bus.mem_doa}),
    .rd_data   (bus.rd_data),
    .empty     (empty),
    .refill    (refill),
    .rd_ptr    (rd_ptr)
  );

  assign out_valid        = ~empty;
  assign bus.empty        = empty;
  assign bus.full         = full_q;
  assign bus.count        = ram_cnt + COUNT_W'(out_valid);
  assign bus.almost_full  = (bus.count >= AFULL_C);
  assign bus.almost_empty = (bus.count <= AEMPTY_C);

  assign bus.mem_we    = push_ok & ~rst;
  assign bus.mem_addrd = wr_ptr;
  assign bus.mem_dia   = bus.wr_data[0];
  assign bus.mem_dib   = bus.wr_data[1];
  assign bus.mem_dic   = bus.wr_data[2];
  assign bus.mem_did   = 1'b0;
  assign bus.mem_addra = rd_ptr;
  assign bus.mem_addrb = rd_ptr;
  assign bus.mem_addrc = rd_ptr;

`ifdef LUTRAM_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en & full_q) overflow_q  <= 1'b1;
      if (bus.rd_en & empty)  underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_lutram_fifo64x3_ctrl.sv
// Directed bench for lutram_fifo64x3_ctrl with a behavioural 64x4 LUT-RAM model.
module tb_lutram_fifo64x3_ctrl;
  import lutram_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  lutram_fifo64x3_ctrl_if bus ();

  lutram_fifo64x3_ctrl #(.AFULL_THRESH(56), .AEMPTY_THRESH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] ram [64];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addrd] <= {bus.mem_did, bus.mem_dic, bus.mem_dib, bus.mem_dia};
  end
  assign bus.mem_doa = ram[bus.mem_addra][0];
  assign bus.mem_dob = ram[bus.mem_addrb][1];
  assign bus.mem_doc = ram[bus.mem_addrc][2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         exp_q[$];
  int         pushes, pops, iters;
  logic [2:0] d;

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 4'h0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 3'd0;
    bus.rd_en   = 1'b0;
    tick();
    tick();
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_aempty", bus.almost_empty, 1);
    check("rst_afull", bus.almost_full, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_did", bus.mem_did, 0);
    rst = 1'b0;

    // single push, two-edge fall-through latency
    bus.wr_data = 3'b101;
    #1;
    check("p1_mem_we", bus.mem_we, 1);
    check("p1_addrd", bus.mem_addrd, 0);
    check("p1_di", {bus.mem_dic, bus.mem_dib, bus.mem_dia}, 5);
    tick();
    bus.wr_en = 1'b0;
    check("p1_no_bypass", bus.empty, 1);
    check("p1_count_e1", bus.count, 1);
    tick();
    check("p1_empty_e2", bus.empty, 0);
    check("p1_rd_data", bus.rd_data, 5);
    check("p1_count_e2", bus.count, 1);

    bus.rd_en = 1'b1;
    tick();
    check("pop1_empty", bus.empty, 1);
    check("pop1_count", bus.count, 0);
    check("pop1_hold", bus.rd_data, 5);
    tick();
    bus.rd_en = 1'b0;
    check("uf_rd_data", bus.rd_data, 5);
    check("uf_addra", bus.mem_addra, 1);
    check("uf_empty", bus.empty, 1);
`ifdef LUTRAM_FIFO_ERR_EN
    check("uf_flag", bus.underflow, 1);
    check("of_flag_clear", bus.overflow, 0);
`endif

    // fill to 65 words, tracking count and thresholds
    for (int i = 0; i < 65; i++) begin
      bus.wr_en   = 1'b1;
      d           = 3'(i);
      bus.wr_data = d;
      tick();
      check("fill_count", bus.count, i + 1);
      check("fill_aempty", bus.almost_empty, (i + 1 <= 2) ? 1 : 0);
      check("fill_afull", bus.almost_full, (i + 1 >= 56) ? 1 : 0);
    end
    check("fill_full", bus.full, 1);
    check("fill_addra", bus.mem_addra, 2);
    bus.wr_data = 3'd7;
    #1;
    check("ovf_mem_we", bus.mem_we, 0);
    check("ovf_addrd", bus.mem_addrd, 2);
    tick();
    check("ovf_addrd_after", bus.mem_addrd, 2);
    check("ovf_count", bus.count, 65);
`ifdef LUTRAM_FIFO_ERR_EN
    check("of_flag", bus.overflow, 1);
`endif

    // full with simultaneous push and pop
    bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("fpp_full", bus.full, 0);
    check("fpp_count", bus.count, 64);
    check("fpp_head", bus.rd_data, 1);
    check("fpp_addrd", bus.mem_addrd, 2);
    check("fpp_addra", bus.mem_addra, 3);

    for (int j = 1; j <= 64; j++) begin
      check("drain_data", bus.rd_data, j % 8);
      bus.rd_en = 1'b1;
      tick();
    end
    bus.rd_en = 1'b0;
    check("drain_empty", bus.empty, 1);
    check("drain_count", bus.count, 0);

    // streaming push/pop of 200 words
    pushes = 0;
    pops   = 0;
    iters  = 0;
    while (pops < 200 && iters < 400) begin
      bus.wr_en = (pushes < 200);
      if (bus.wr_en) begin
        d           = 3'(pushes);
        bus.wr_data = d;
        if (!bus.full) begin
          exp_q.push_back(pushes % 8);
          pushes++;
        end
      end
      bus.rd_en = ~bus.empty;
      if (bus.rd_en) begin
        if (exp_q.size() > 0) check("stream_data", bus.rd_data, exp_q.pop_front());
        else check("stream_underrun", 1, 0);
        pops++;
      end
      tick();
      iters++;
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("stream_pops", pops, 200);
    check("stream_cycles", iters, 202);
    check("stream_addrd", bus.mem_addrd, 10);
    check("stream_addra", bus.mem_addra, 10);
    check("stream_empty", bus.empty, 1);

    // reset mid-operation with 10 words held
    for (int k = 0; k < 10; k++) begin
      bus.wr_en   = 1'b1;
      d           = 3'(k);
      bus.wr_data = d;
      tick();
    end
    check("pre_rst_count", bus.count, 10);
    rst = 1'b1;
    #1;
    check("mid_rst_mem_we", bus.mem_we, 0);
    check("mid_rst_empty", bus.empty, 1);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_aempty", bus.almost_empty, 1);
    check("mid_rst_addrd", bus.mem_addrd, 0);
`ifdef LUTRAM_FIFO_ERR_EN
    check("mid_rst_uf", bus.underflow, 0);
    check("mid_rst_of", bus.overflow, 0);
`endif
    tick();
    rst         = 1'b0;
    bus.wr_data = 3'b110;
    #1;
    check("post_rst_we", bus.mem_we, 1);
    check("post_rst_addrd", bus.mem_addrd, 0);
    tick();
    bus.wr_en = 1'b0;
    tick();
    check("post_rst_data", bus.rd_data, 6);
    check("post_rst_empty", bus.empty, 0);
    check("post_rst_count", bus.count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
